// File: rtl/riscv_pkg.sv
// Shared datapath constants and the operand bank state type.
package riscv_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] X0_ADDR = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_e;
endpackage

// File: rtl/operand_chan.sv
// One operand channel: data/address register with capture-time and hold-time
// write-back forwarding.
module operand_chan #(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter int unsigned AW       = riscv_pkg::REG_AW,
  parameter int unsigned ZERO_FWD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_capture,
  input  logic            i_hold,
  input  logic [XLEN-1:0] i_rd_data,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic            i_wb_en,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_data,
  output logic [AW-1:0]   o_addr
);
  import riscv_pkg::*;

  localparam bit ZF = (ZERO_FWD != 0);

  logic [XLEN-1:0] r_data;
  logic [AW-1:0]   r_addr;
  logic            w_wb_ok;
  logic            w_cap_fwd;
  logic            w_hold_fwd;
  logic            w_rd_zero;
  logic [XLEN-1:0] w_cap_data;

  // Write-back to x0 is ignored unless zero forwarding is enabled.
  assign w_wb_ok    = i_wb_en & (ZF | (i_wb_addr != AW'(X0_ADDR)));
  assign w_cap_fwd  = w_wb_ok & (i_wb_addr == i_rd_addr);
  assign w_hold_fwd = w_wb_ok & (i_wb_addr == r_addr);
  assign w_rd_zero  = !ZF & (i_rd_addr == AW'(X0_ADDR));

  always_comb begin
    w_cap_data = i_rd_data;
    if (w_cap_fwd) begin
      w_cap_data = i_wb_data;
    end else if (w_rd_zero) begin
      w_cap_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_addr <= '0;
    end else if (i_capture) begin
      r_data <= w_cap_data;
      r_addr <= i_rd_addr;
    end else if (i_hold && w_hold_fwd) begin
      r_data <= i_wb_data;
    end
  end

  assign o_data = r_data;
  assign o_addr = r_addr;
endmodule

// File: rtl/operand_reg_bank.sv
// Register-file output operand bank: valid/ready handshake, per-channel
// forwarding registers, flush and a saturating stall counter.
module operand_reg_bank #(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned AW       = riscv_pkg::REG_AW,
  parameter int unsigned ZERO_FWD = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CH*XLEN-1:0] rd_data,
  input  logic [NUM_CH*AW-1:0]   rd_addr,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CH*XLEN-1:0] out_data,
  output logic [NUM_CH*AW-1:0]   out_addr,
  output logic [CNT_W-1:0]       hold_cnt
);
  import riscv_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bank_state_e      r_state;
  bank_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic             w_capture;
  logic             w_hold;

  assign out_valid = (r_state == FULL);
  assign in_ready  = !out_valid | out_ready;
  // A flush squashes any capture presented in the same cycle.
  assign w_capture = in_valid & in_ready & !flush;
  assign w_hold    = out_valid & !w_capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = '0;
    case (r_state)
      EMPTY: begin
        if (w_capture) w_state_nxt = FULL;
      end
      FULL: begin
        if (!w_capture && out_ready) w_state_nxt = EMPTY;
        if (!out_ready) begin
          w_hold_cnt_nxt = (r_hold_cnt == CNT_MAX) ? r_hold_cnt : r_hold_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) begin
      w_state_nxt    = EMPTY;
      w_hold_cnt_nxt = '0;
    end
  end

  assign hold_cnt = r_hold_cnt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    operand_chan #(
      .XLEN    (XLEN),
      .AW      (AW),
      .ZERO_FWD(ZERO_FWD)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .i_capture(w_capture),
      .i_hold   (w_hold),
      .i_rd_data(rd_data[g*XLEN +: XLEN]),
      .i_rd_addr(rd_addr[g*AW +: AW]),
      .i_wb_en  (wb_en),
      .i_wb_addr(wb_addr),
      .i_wb_data(wb_data),
      .o_data   (out_data[g*XLEN +: XLEN]),
      .o_addr   (out_addr[g*AW +: AW])
    );
  end
endmodule

// File: tb/tb_operand_reg_bank.sv
// Randomised and directed bench for operand_reg_bank against a behavioural model.
module tb_operand_reg_bank;
  localparam int XLEN   = 32;
  localparam int NUM_CH = 2;
  localparam int AW     = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_CH*XLEN-1:0] rd_data;
  logic [NUM_CH*AW-1:0]   rd_addr;
  logic                   wb_en;
  logic [AW-1:0]          wb_addr;
  logic [XLEN-1:0]        wb_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_CH*XLEN-1:0] out_data;
  logic [NUM_CH*AW-1:0]   out_addr;
  logic [CNT_W-1:0]       hold_cnt;

  int n_vec = 0;
  int n_err = 0;

  operand_reg_bank #(
    .XLEN(XLEN), .NUM_CH(NUM_CH), .AW(AW), .ZERO_FWD(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rd_data(rd_data), .rd_addr(rd_addr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .hold_cnt(hold_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the bank is a one-entry queue whose contents are
  // patched by write-backs to matching non-zero registers.
  logic            m_valid;
  int              m_cnt;
  logic [XLEN-1:0] m_data [NUM_CH];
  logic [AW-1:0]   m_addr [NUM_CH];

  always @(posedge clk) begin
    bit accept;
    logic [AW-1:0] a;
    if (reset) begin
      m_valid = 1'b0;
      m_cnt   = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_data[c] = '0;
        m_addr[c] = '0;
      end
    end else begin
      accept = in_valid && (!m_valid || out_ready) && !flush;
      if (flush || !m_valid || out_ready) m_cnt = 0;
      else if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept) begin
          a = rd_addr[c*AW +: AW];
          if (wb_en && wb_addr == a && a != 0) m_data[c] = wb_data;
          else if (a == 0) m_data[c] = '0;
          else m_data[c] = rd_data[c*XLEN +: XLEN];
          m_addr[c] = a;
        end else if (m_valid && wb_en && wb_addr != 0 && wb_addr == m_addr[c]) begin
          m_data[c] = wb_data;
        end
      end
      if (flush) m_valid = 1'b0;
      else if (accept) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
    check("hold_cnt", 64'(hold_cnt), 64'(m_cnt));
    if (m_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        check("out_data", 64'(out_data[c*XLEN +: XLEN]), 64'(m_data[c]));
        check("out_addr", 64'(out_addr[c*AW +: AW]), 64'(m_addr[c]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; rd_data = '0; rd_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_cnt", 64'(hold_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Simple capture then stall.
    in_valid = 1'b1; rd_addr = {5'd2, 5'd1}; rd_data = {32'hB, 32'hA};
    tick();
    in_valid = 1'b0;
    check("cap_valid", 64'(out_valid), 64'd1);
    check("cap_data", 64'(out_data), 64'h0000000B_0000000A);
    check("cap_in_ready", 64'(in_ready), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("stall_cnt", 64'(hold_cnt), 64'(k));
    end

    // Capture-time forward, back-to-back with the stalled entry.
    out_ready = 1'b1; in_valid = 1'b1;
    rd_addr = {5'd3, 5'd5}; rd_data = {32'h22, 32'h11};
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h99;
    tick();
    check("capfwd_data", 64'(out_data), 64'h00000022_00000099);
    check("capfwd_cnt", 64'(hold_cnt), 64'd0);
    rd_addr = {5'd3, 5'd0}; rd_data = {32'h33, 32'h77}; wb_addr = 5'd0; wb_data = 32'h55;
    tick();
    check("x0_data", 64'(out_data), 64'h00000033_00000000);

    // Held forward to two channels sharing an address.
    wb_en = 1'b0; rd_addr = {5'd7, 5'd7}; rd_data = {32'h1, 32'h2};
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
    tick();
    wb_en = 1'b0;
    check("holdfwd_data", 64'(out_data), 64'h00001234_00001234);
    check("holdfwd_valid", 64'(out_valid), 64'd1);

    // Back-to-back replace.
    out_ready = 1'b1; in_valid = 1'b1; rd_addr = {5'd9, 5'd8}; rd_data = {32'hC, 32'hC};
    tick();
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_data", 64'(out_data), 64'h0000000C_0000000C);
    check("b2b_cnt", 64'(hold_cnt), 64'd0);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Flush squashes a capture while empty.
    out_ready = 1'b0; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);

    // Stall to saturation, then reset mid-stall.
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("cnt5", 64'(hold_cnt), 64'd5);
    for (int k = 0; k < 15; k++) tick();
    check("cnt_sat", 64'(hold_cnt), 64'(CMAX));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_data", 64'(out_data), 64'd0);
    check("mrst_addr", 64'(out_addr), 64'd0);
    check("mrst_cnt", 64'(hold_cnt), 64'd0);

    // Random traffic with narrow address ranges to provoke forwarding.
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 45);
      flush     = ($urandom_range(0, 99) < 5);
      reset     = ($urandom_range(0, 199) == 0);
      wb_en     = ($urandom_range(0, 99) < 50);
      wb_addr   = AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      for (int c = 0; c < NUM_CH; c++) begin
        rd_addr[c*AW +: AW]   = AW'($urandom_range(0, 7));
        rd_data[c*XLEN +: XLEN] = $urandom;
      end
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
